// File: rtl/cpu_periph_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_periph_pkg
// Brief    : Shared address map and TCON bit layout for the CPU peripheral bus.
// Revision : 1.0
// ============================================================================
package cpu_periph_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

  localparam logic [4:0] TH_OFF      = 5'h00;
  localparam logic [4:0] TL_OFF      = 5'h04;
  localparam logic [4:0] TCON_OFF    = 5'h08;
  localparam logic [4:0] SYSTICK_OFF = 5'h14;

  localparam int TCON_EN    = 0;
  localparam int TCON_IRQEN = 1;
  localparam int TCON_IRQ   = 2;

  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    SEL_TH      = 3'd1,
    SEL_TL      = 3'd2,
    SEL_TCON    = 3'd3,
    SEL_SYSTICK = 3'd4
  } reg_sel_t;

  // The window is 32 bytes, so only addr[4:2] selects a register once the base matches.
  function automatic reg_sel_t decode_addr(input logic [31:0] addr, input logic [31:0] base);
    reg_sel_t sel;
    sel = SEL_NONE;
    if (addr[31:5] == base[31:5]) begin
      case ({addr[4:2], 2'b00})
        TH_OFF:      sel = SEL_TH;
        TL_OFF:      sel = SEL_TL;
        TCON_OFF:    sel = SEL_TCON;
        SYSTICK_OFF: sel = SEL_SYSTICK;
        default:     sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_periph_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_periph_if
// Brief    : MEM-stage load/store strobes, read-back path and timer interrupt.
// Revision : 1.0
// ============================================================================
interface timer_periph_if;
  logic        MemReadMEM;
  logic        MemWriteMEM;
  logic [31:0] memaddrMEM;
  logic [31:0] memwritedataMEM;
  logic        periphhitMEM;
  logic [31:0] periphreaddataMEM;
  logic        intterupt;

  modport master (
    output MemReadMEM, MemWriteMEM, memaddrMEM, memwritedataMEM,
    input  periphhitMEM, periphreaddataMEM, intterupt
  );

  modport slave (
    input  MemReadMEM, MemWriteMEM, memaddrMEM, memwritedataMEM,
    output periphhitMEM, periphreaddataMEM, intterupt
  );
endinterface
`default_nettype wire

// File: rtl/timer_periph_tick_divider.sv
`default_nettype none
// ============================================================================
// Module   : tick_divider
// Brief    : Prescaler emitting one tick every PRESCALE enabled cycles.
// Revision : 1.0
// ============================================================================
module tick_divider #(
  parameter int PRESCALE = 1
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic enable,
  input  wire logic clear,
  output logic      tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  // Count holds while disabled so a re-enable resumes mid-period.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_periph.sv
`default_nettype none
// ============================================================================
// Module   : timer_periph
// Brief    : Reloadable 32-bit timer, free-running SYSTICK and level interrupt.
// Revision : 1.0
// ============================================================================
module timer_periph
  import cpu_periph_pkg::*;
#(
  parameter int          PRESCALE = 1,
  parameter logic [31:0] BASE     = PERIPH_BASE
) (
  input  wire logic       clk,
  input  wire logic       reset,
  timer_periph_if.slave   bus
);

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;

  reg_sel_t sel;
  logic     wr_th, wr_tl, wr_tcon;
  logic     tick;
  logic     overflow;
  logic     irq_set;

  assign sel     = decode_addr(bus.memaddrMEM, BASE);
  assign wr_th   = bus.MemWriteMEM && (sel == SEL_TH);
  assign wr_tl   = bus.MemWriteMEM && (sel == SEL_TL);
  assign wr_tcon = bus.MemWriteMEM && (sel == SEL_TCON);

  tick_divider #(.PRESCALE(PRESCALE)) u_div (
    .clk    (clk),
    .reset  (reset),
    .enable (tcon[TCON_EN]),
    .clear  (wr_tcon),
    .tick   (tick)
  );

  assign overflow = tick && (tl == 32'hFFFF_FFFF);
  assign irq_set  = overflow && tcon[TCON_IRQEN];

  always_ff @(posedge clk) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (wr_th) th <= bus.memwritedataMEM;
      // CPU write to TL wins over the tick; a reload reads TH before its own write lands.
      if (wr_tl)         tl <= bus.memwritedataMEM;
      else if (overflow) tl <= th;
      else if (tick)     tl <= tl + 32'd1;
      if (wr_tcon) begin
        tcon[TCON_EN]    <= bus.memwritedataMEM[TCON_EN];
        tcon[TCON_IRQEN] <= bus.memwritedataMEM[TCON_IRQEN];
        tcon[TCON_IRQ]   <= (tcon[TCON_IRQ] & bus.memwritedataMEM[TCON_IRQ]) | irq_set;
      end else begin
        tcon[TCON_IRQ]   <= tcon[TCON_IRQ] | irq_set;
      end
    end
  end

  always_comb begin
    bus.periphreaddataMEM = '0;
    case (sel)
      SEL_TH:      bus.periphreaddataMEM = th;
      SEL_TL:      bus.periphreaddataMEM = tl;
      SEL_TCON:    bus.periphreaddataMEM = {29'd0, tcon};
      SEL_SYSTICK: bus.periphreaddataMEM = systick;
      default:     bus.periphreaddataMEM = '0;
    endcase
  end

  assign bus.periphhitMEM = (sel != SEL_NONE);
  assign bus.intterupt    = tcon[TCON_IRQ];

endmodule
`default_nettype wire
